// File: rtl/reflex_game_ctrl.sv
// reflex_game_ctrl
// Sequencing controller for the reflex-timer game.
// IDLE -> ARMED (pseudo-random wait) -> LIT (reaction measured in ms) -> result.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   i_ready_pulse   debounced one-cycle pulse: arm / restart
//   i_fire_pulse    debounced one-cycle pulse: player response
//   o_led_out       stimulus light, high only in LIT
//   o_bcd_time      {hundreds,tens,units} BCD reaction time in ms, 12'hFFF on foul
//   o_result_valid  high in DONE, FOUL, TIMEOUT
//   o_foul          high in FOUL only
//   o_busy          high in ARMED or LIT
//   o_state         current state encoding (see table)
//   o_best_time     best BCD result since reset           (BEST_TIME_EN only)
//   o_new_best      one-cycle pulse when best_time updates (BEST_TIME_EN only)
//
// Optional feature macro: BEST_TIME_EN
//
// state   | meaning
// IDLE    | waiting for ready
// ARMED   | random wait running, fire here is a foul
// LIT     | LED on, reaction time counting
// DONE    | valid reaction time held
// FOUL    | player fired early, bcd_time = FFF
// TIMEOUT | no response within 999 ms, bcd_time = 999

module reflex_game_ctrl #(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned DELAY_BASE_MS = 1000,
    parameter int unsigned DELAY_STEP_MS = 250,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ready_pulse,
    input  logic        i_fire_pulse,
    output logic        o_led_out,
    output logic [11:0] o_bcd_time,
    output logic        o_result_valid,
    output logic        o_foul,
    output logic        o_busy,
    output logic [2:0]  o_state
`ifdef BEST_TIME_EN
    ,
    output logic [11:0] o_best_time,
    output logic        o_new_best
`endif
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DELAY_MAX = DELAY_BASE_MS + 7 * DELAY_STEP_MS;
    localparam int DW = (DELAY_MAX > 1) ? $clog2(DELAY_MAX + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_LIT     = 3'd2,
        S_DONE    = 3'd3,
        S_FOUL    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_lfsr;
    logic            w_lfsr_fb;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_ms_tick;
    logic [DW-1:0]   r_delay_ms;
    logic [DW-1:0]   r_wait_cnt;
    logic            w_wait_last;
    logic            w_bcd_max;
    logic            w_enter_armed;
    logic            w_enter_lit;
    logic            r_led_out;
    logic [11:0]     r_bcd_time;
    logic            r_result_valid;
    logic            r_foul;
    logic            r_busy;
`ifdef BEST_TIME_EN
    logic [11:0]     r_best_time;
    logic            r_new_best;
`endif

    // BCD +1 with units/tens carry; only called below 999
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    // Fibonacci taps 8,6,5,4
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_ms_tick   = (r_tick_cnt == TICK_LAST);
    assign w_wait_last = (r_wait_cnt == (r_delay_ms - DW'(1)));
    assign w_bcd_max   = (r_bcd_time == 12'h999);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FOUL, S_TIMEOUT: begin
                if (i_ready_pulse) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (i_fire_pulse)                   w_state_nxt = S_FOUL;
                else if (w_ms_tick && w_wait_last)  w_state_nxt = S_LIT;
            end
            S_LIT: begin
                if (i_fire_pulse)                   w_state_nxt = S_DONE;
                else if (w_ms_tick && w_bcd_max)    w_state_nxt = S_TIMEOUT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_armed = (w_state_nxt == S_ARMED) && (r_state != S_ARMED);
    assign w_enter_lit   = (w_state_nxt == S_LIT)   && (r_state != S_LIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_lfsr         <= LFSR_SEED;
            r_tick_cnt     <= '0;
            r_delay_ms     <= '0;
            r_wait_cnt     <= '0;
            r_led_out      <= 1'b0;
            r_bcd_time     <= 12'h000;
            r_result_valid <= 1'b0;
            r_foul         <= 1'b0;
            r_busy         <= 1'b0;
`ifdef BEST_TIME_EN
            r_best_time    <= 12'h999;
            r_new_best     <= 1'b0;
`endif
        end else begin
            r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};
            r_state <= w_state_nxt;

            // Outputs decoded from the next state so they move with o_state
            r_led_out      <= (w_state_nxt == S_LIT);
            r_busy         <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_LIT);
            r_result_valid <= (w_state_nxt == S_DONE) || (w_state_nxt == S_FOUL) ||
                              (w_state_nxt == S_TIMEOUT);
            r_foul         <= (w_state_nxt == S_FOUL);

            // Realign the ms prescaler so wait and measurement are whole ticks
            if (w_enter_armed || w_enter_lit || w_ms_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + TW'(1);

            if (w_enter_armed) begin
                r_delay_ms <= DW'(DELAY_BASE_MS + 32'(r_lfsr[2:0]) * DELAY_STEP_MS);
                r_wait_cnt <= '0;
                r_bcd_time <= 12'h000;
            end else begin
                if (r_state == S_ARMED && w_ms_tick)
                    r_wait_cnt <= r_wait_cnt + DW'(1);
                if (w_state_nxt == S_FOUL)
                    r_bcd_time <= 12'hFFF;
                // fire and the 999 timeout both leave the count untouched
                else if (r_state == S_LIT && w_state_nxt == S_LIT && w_ms_tick)
                    r_bcd_time <= bcd_inc(r_bcd_time);
            end

`ifdef BEST_TIME_EN
            r_new_best <= 1'b0;
            // BCD digits compare correctly as plain binary
            if (r_state == S_LIT && w_state_nxt == S_DONE && r_bcd_time < r_best_time) begin
                r_best_time <= r_bcd_time;
                r_new_best  <= 1'b1;
            end
`endif
        end
    end

    assign o_led_out      = r_led_out;
    assign o_bcd_time     = r_bcd_time;
    assign o_result_valid = r_result_valid;
    assign o_foul         = r_foul;
    assign o_busy         = r_busy;
    assign o_state        = r_state;
`ifdef BEST_TIME_EN
    assign o_best_time    = r_best_time;
    assign o_new_best     = r_new_best;
`endif

endmodule

// File: tb/tb_reflex_game_ctrl.sv
// Testbench for reflex_game_ctrl with TICK_DIV=4, DELAY_BASE_MS=3, DELAY_STEP_MS=0.
// Results are pushed to a scoreboard when fire is driven and popped by a
// monitor when result_valid rises.

module tb_reflex_game_ctrl;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_ready_pulse = 1'b0;
    logic        i_fire_pulse = 1'b0;
    logic        o_led_out;
    logic [11:0] o_bcd_time;
    logic        o_result_valid;
    logic        o_foul;
    logic        o_busy;
    logic [2:0]  o_state;
`ifdef BEST_TIME_EN
    logic [11:0] o_best_time;
    logic        o_new_best;
`endif

    typedef struct {
        logic [2:0]  st;
        logic [11:0] bcd;
        logic        foul;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_prev_rv = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int model_best = 999;
    int nb_count = 0;
    bit best_track = 1'b0;

    reflex_game_ctrl #(
        .TICK_DIV      (TICK),
        .DELAY_BASE_MS (3),
        .DELAY_STEP_MS (0),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_ready_pulse  (i_ready_pulse),
        .i_fire_pulse   (i_fire_pulse),
        .o_led_out      (o_led_out),
        .o_bcd_time     (o_bcd_time),
        .o_result_valid (o_result_valid),
        .o_foul         (o_foul),
        .o_busy         (o_busy),
        .o_state        (o_state)
`ifdef BEST_TIME_EN
        ,
        .o_best_time    (o_best_time),
        .o_new_best     (o_new_best)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int from_bcd(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready;
        i_ready_pulse = 1'b1;
        step();
        i_ready_pulse = 1'b0;
    endtask

    task automatic pulse_fire;
        i_fire_pulse = 1'b1;
        step();
        i_fire_pulse = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [11:0] bcd, input logic foul);
        exp_t e;
        e.st = st;
        e.bcd = bcd;
        e.foul = foul;
        sb.push_back(e);
    endtask

    task automatic wait_lit(input string name);
        int n = 0;
        while (o_state != 3'd2 && n < 40) begin
            step();
            n++;
        end
        n_tests++;
        if (o_state !== 3'd2) begin
            n_fail++;
            $display("FAIL %s_wait_lit: state=%0d after %0d cycles, want 2", name, o_state, n);
        end
    endtask

    // Scoreboard monitor, samples on the falling edge
    always @(negedge clk) begin
        if (reset && o_result_valid && !mon_prev_rv) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: result state=%0d bcd=%h with empty scoreboard",
                         o_state, o_bcd_time);
            end else begin
                mon_e = sb.pop_front();
                if (o_state !== mon_e.st || o_bcd_time !== mon_e.bcd ||
                    o_foul !== mon_e.foul || o_led_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_result: got state=%0d bcd=%h foul=%b led=%b, want state=%0d bcd=%h foul=%b led=0",
                             o_state, o_bcd_time, o_foul, o_led_out, mon_e.st, mon_e.bcd, mon_e.foul);
                end
            end
        end
        mon_prev_rv = reset ? o_result_valid : 1'b0;
    end

    // Arm, wait for LIT, fire fire_after cycles after LIT entry
    task automatic run_reaction(input int fire_after);
        logic [11:0] exp_bcd;
        bit improved;
        exp_bcd = to_bcd((fire_after - 1) / TICK);
        pulse_ready();
        wait_lit("reaction");
        repeat (fire_after - 1) step();
        push_exp(3'd3, exp_bcd, 1'b0);
        pulse_fire();
        n_tests++;
        if (o_state !== 3'd3 || o_bcd_time !== exp_bcd) begin
            n_fail++;
            $display("FAIL reaction_%0d: state=%0d bcd=%h, want state=3 bcd=%h",
                     fire_after, o_state, o_bcd_time, exp_bcd);
        end
`ifdef BEST_TIME_EN
        if (best_track) begin
            improved = (from_bcd(exp_bcd) < model_best);
            if (improved) model_best = from_bcd(exp_bcd);
            if (o_new_best === 1'b1) nb_count++;
            n_tests++;
            if (o_new_best !== improved || o_best_time !== to_bcd(model_best)) begin
                n_fail++;
                $display("FAIL best_update_%0d: new_best=%b best=%h, want new_best=%b best=%h",
                         fire_after, o_new_best, o_best_time, improved, to_bcd(model_best));
            end
            step();
            n_tests++;
            if (o_new_best !== 1'b0) begin
                n_fail++;
                $display("FAIL best_pulse_width: new_best=%b, want 0", o_new_best);
            end
        end
`else
        improved = 1'b0;
        if (improved) step();
`endif
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        n_tests++;
        if (o_state !== 3'd0 || o_led_out !== 1'b0 || o_bcd_time !== 12'h000 ||
            o_result_valid !== 1'b0 || o_foul !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d led=%b bcd=%h rv=%b foul=%b busy=%b, want all zero",
                     o_state, o_led_out, o_bcd_time, o_result_valid, o_foul, o_busy);
        end
        repeat (20) step();
        n_tests++;
        if (o_state !== 3'd0 || o_led_out !== 1'b0 || o_bcd_time !== 12'h000 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d led=%b bcd=%h busy=%b, want 0 0 000 0",
                     o_state, o_led_out, o_bcd_time, o_busy);
        end
    endtask

    task automatic test_normal;
        pulse_ready();
        n_tests++;
        if (o_state !== 3'd1 || o_busy !== 1'b1 || o_led_out !== 1'b0 || o_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arm: state=%0d busy=%b led=%b rv=%b, want 1 1 0 0",
                     o_state, o_busy, o_led_out, o_result_valid);
        end
        repeat (11) step();
        n_tests++;
        if (o_state !== 3'd1 || o_led_out !== 1'b0) begin
            n_fail++;
            $display("FAIL armed_11: state=%0d led=%b, want 1 0", o_state, o_led_out);
        end
        step();
        n_tests++;
        if (o_state !== 3'd2 || o_led_out !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lit_12: state=%0d led=%b busy=%b, want 2 1 1", o_state, o_led_out, o_busy);
        end
        repeat (20) step();
        push_exp(3'd3, 12'h005, 1'b0);
        pulse_fire();
        n_tests++;
        if (o_state !== 3'd3 || o_bcd_time !== 12'h005 || o_result_valid !== 1'b1 ||
            o_led_out !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_005: state=%0d bcd=%h rv=%b led=%b busy=%b, want 3 005 1 0 0",
                     o_state, o_bcd_time, o_result_valid, o_led_out, o_busy);
        end
        run_reaction(9);
    endtask

    task automatic test_foul;
        pulse_ready();
        n_tests++;
        if (o_state !== 3'd1 || o_foul !== 1'b0 || o_bcd_time !== 12'h000 || o_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_from_done: state=%0d foul=%b bcd=%h rv=%b, want 1 0 000 0",
                     o_state, o_foul, o_bcd_time, o_result_valid);
        end
        repeat (4) step();
        push_exp(3'd4, 12'hFFF, 1'b1);
        pulse_fire();
        n_tests++;
        if (o_state !== 3'd4 || o_foul !== 1'b1 || o_bcd_time !== 12'hFFF || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL foul: state=%0d foul=%b bcd=%h busy=%b, want 4 1 FFF 0",
                     o_state, o_foul, o_bcd_time, o_busy);
        end
        pulse_fire();
        repeat (3) step();
        n_tests++;
        if (o_state !== 3'd4 || o_foul !== 1'b1 || o_bcd_time !== 12'hFFF) begin
            n_fail++;
            $display("FAIL foul_fire_ignored: state=%0d foul=%b bcd=%h, want 4 1 FFF",
                     o_state, o_foul, o_bcd_time);
        end
        pulse_ready();
        n_tests++;
        if (o_state !== 3'd1 || o_foul !== 1'b0 || o_bcd_time !== 12'h000 ||
            o_busy !== 1'b1 || o_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_from_foul: state=%0d foul=%b bcd=%h busy=%b rv=%b, want 1 0 000 1 0",
                     o_state, o_foul, o_bcd_time, o_busy, o_result_valid);
        end
    endtask

    // Entered in ARMED; runs to the 999 ms timeout checking every increment
    task automatic test_timeout;
        logic [11:0] prev;
        logic [11:0] exp_v;
        int cyc;
        wait_lit("timeout");
        prev = o_bcd_time;
        n_tests++;
        if (prev !== 12'h000) begin
            n_fail++;
            $display("FAIL lit_start: bcd=%h, want 000", prev);
        end
        push_exp(3'd5, 12'h999, 1'b0);
        cyc = 0;
        while (cyc < 4100 && !o_result_valid) begin
            step();
            cyc++;
            if (!o_result_valid && o_bcd_time !== prev) begin
                exp_v = to_bcd(from_bcd(prev) + 1);
                n_tests++;
                if (o_bcd_time !== exp_v || (cyc % TICK) != 0) begin
                    n_fail++;
                    $display("FAIL bcd_count: cycle %0d bcd=%h after %h, want %h on a multiple of %0d",
                             cyc, o_bcd_time, prev, exp_v, TICK);
                end
                prev = o_bcd_time;
            end
        end
        n_tests++;
        if (cyc != 4000 || o_state !== 3'd5 || o_bcd_time !== 12'h999 || o_led_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: after %0d cycles state=%0d bcd=%h led=%b, want 4000 cycles state=5 bcd=999 led=0",
                     cyc, o_state, o_bcd_time, o_led_out);
        end
    endtask

    task automatic test_fire_on_tick;
        run_reaction(32);
    endtask

    task automatic test_reset_mid_lit;
        pulse_ready();
        wait_lit("mid_lit");
        repeat (5) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_tests++;
        if (o_state !== 3'd0 || o_led_out !== 1'b0 || o_busy !== 1'b0 || o_bcd_time !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_lit: state=%0d led=%b busy=%b bcd=%h, want 0 0 0 000",
                     o_state, o_led_out, o_busy, o_bcd_time);
        end
        pulse_fire();
        step();
        n_tests++;
        if (o_state !== 3'd0 || o_foul !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_fire_ignored: state=%0d foul=%b, want 0 0", o_state, o_foul);
        end
    endtask

    task automatic test_ready_fire_same;
        i_ready_pulse = 1'b1;
        i_fire_pulse  = 1'b1;
        step();
        i_ready_pulse = 1'b0;
        i_fire_pulse  = 1'b0;
        n_tests++;
        if (o_state !== 3'd1 || o_foul !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_fire_idle: state=%0d foul=%b busy=%b, want 1 0 1", o_state, o_foul, o_busy);
        end
        repeat (3) step();
        n_tests++;
        if (o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL ready_fire_hold: state=%0d, want 1", o_state);
        end
    endtask

`ifdef BEST_TIME_EN
    task automatic test_best;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        n_tests++;
        if (o_best_time !== 12'h999 || o_new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL best_reset: best=%h new_best=%b, want 999 0", o_best_time, o_new_best);
        end
        model_best = 999;
        nb_count = 0;
        best_track = 1'b1;
        run_reaction(21);
        run_reaction(13);
        run_reaction(17);
        n_tests++;
        if (o_best_time !== 12'h003 || nb_count != 2) begin
            n_fail++;
            $display("FAIL best_sequence: best=%h pulses=%0d, want 003 2", o_best_time, nb_count);
        end
        pulse_ready();
        repeat (4) step();
        push_exp(3'd4, 12'hFFF, 1'b1);
        pulse_fire();
        step();
        n_tests++;
        if (o_state !== 3'd4 || o_best_time !== 12'h003 || o_new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL best_after_foul: state=%0d best=%h new_best=%b, want 4 003 0",
                     o_state, o_best_time, o_new_best);
        end
        best_track = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_foul();
        test_timeout();
        test_fire_on_tick();
        test_reset_mid_lit();
        test_ready_fire_same();
`ifdef BEST_TIME_EN
        test_best();
`endif
        repeat (2) step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected results never produced, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
